// File: rtl/phase_diff_unwrap_if.sv
// rtl/phase_diff_unwrap_if.sv - angle-in / phase-difference-out stream bundle
interface phase_diff_unwrap_if #(
    parameter int W = 32
);
    logic signed [W-1:0] theta_in;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] dphase;
    logic                dphase_valid;
    logic                dphase_ready;

    modport master (
        output theta_in, in_valid, dphase_ready,
        input  in_ready, dphase, dphase_valid
    );

    modport slave (
        input  theta_in, in_valid, dphase_ready,
        output in_ready, dphase, dphase_valid
    );
endinterface

// File: rtl/phase_diff_unwrap.sv
// rtl/phase_diff_unwrap.sv - wrap-corrected phase difference, unwrapped phase and block average
module phase_diff_unwrap #(
    parameter int W        = 32,
    parameter int UW       = 40,
    parameter int PI_CODE  = 205887,
    parameter int AVG_LOG2 = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    phase_diff_unwrap_if.slave   s,
    output logic signed [UW-1:0] unwrapped,
    output logic signed [W-1:0]  avg_out,
    output logic                 avg_valid,
    output logic                 range_err
);
    typedef enum logic [0:0] {EMPTY, TRACK} state_t;

    localparam int SW = W + AVG_LOG2;
    localparam logic signed [W+1:0] PI_X     = (W+2)'(PI_CODE);
    localparam logic signed [W+1:0] TWO_PI_X = (W+2)'(2 * PI_CODE);

    state_t                state;
    logic signed [W-1:0]   prev;
    logic signed [SW-1:0]  sum;
    logic [AVG_LOG2-1:0]   count;

    logic                  accept;
    logic signed [W+1:0]   theta_x;
    logic signed [W+1:0]   prev_x;
    logic signed [W+1:0]   raw;
    logic signed [W+1:0]   d_full;
    logic signed [W-1:0]   d;
    logic signed [SW-1:0]  sum_next;
    logic signed [SW-1:0]  avg_full;
    logic                  out_of_range;

    assign s.in_ready = rst & ~clear & (~s.dphase_valid | s.dphase_ready);
    assign accept     = s.in_valid & s.in_ready;

    // Two guard bits keep both the raw difference and its +/-2pi correction exact.
    always_comb begin
        theta_x = {{2{s.theta_in[W-1]}}, s.theta_in};
        prev_x  = {{2{prev[W-1]}}, prev};
        raw     = theta_x - prev_x;
        d_full  = raw;
        if (raw > PI_X)
            d_full = raw - TWO_PI_X;
        else if (raw < -PI_X)
            d_full = raw + TWO_PI_X;
        d            = d_full[W-1:0];
        out_of_range = (theta_x > PI_X) || (theta_x < -PI_X);
        sum_next     = sum + {{AVG_LOG2{d[W-1]}}, d};
        avg_full     = sum_next >>> AVG_LOG2;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= EMPTY;
            prev           <= '0;
            sum            <= '0;
            count          <= '0;
            s.dphase       <= '0;
            s.dphase_valid <= 1'b0;
            unwrapped      <= '0;
            avg_out        <= '0;
            avg_valid      <= 1'b0;
            range_err      <= 1'b0;
        end else if (clear) begin
            state          <= EMPTY;
            prev           <= '0;
            sum            <= '0;
            count          <= '0;
            s.dphase       <= '0;
            s.dphase_valid <= 1'b0;
            unwrapped      <= '0;
            avg_out        <= '0;
            avg_valid      <= 1'b0;
            range_err      <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (accept) begin
                prev <= s.theta_in;
                if (out_of_range)
                    range_err <= 1'b1;
                if (state == EMPTY) begin
                    unwrapped <= {{(UW-W){s.theta_in[W-1]}}, s.theta_in};
                    state     <= TRACK;
                end else begin
                    s.dphase       <= d;
                    s.dphase_valid <= 1'b1;
                    unwrapped      <= unwrapped + {{(UW-W){d[W-1]}}, d};
                    // Window closes on the 2^AVG_LOG2-th difference, which is folded in here.
                    if (count == {AVG_LOG2{1'b1}}) begin
                        avg_out   <= avg_full[W-1:0];
                        avg_valid <= 1'b1;
                        sum       <= '0;
                        count     <= '0;
                    end else begin
                        sum   <= sum_next;
                        count <= count + 1'b1;
                    end
                end
            end else if (s.dphase_ready) begin
                s.dphase_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_phase_diff_unwrap.sv
// tb/tb_phase_diff_unwrap.sv - directed vector bench for phase_diff_unwrap
module tb_phase_diff_unwrap;
    localparam int W  = 32;
    localparam int UW = 40;

    logic clk;
    logic rst;
    logic clear;
    logic signed [UW-1:0] unwrapped;
    logic signed [W-1:0]  avg_out;
    logic                 avg_valid;
    logic                 range_err;

    phase_diff_unwrap_if #(.W(W)) bus ();

    phase_diff_unwrap #(
        .W(W), .UW(UW), .PI_CODE(205887), .AVG_LOG2(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .s         (bus),
        .unwrapped (unwrapped),
        .avg_out   (avg_out),
        .avg_valid (avg_valid),
        .range_err (range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic                 clr;
        logic                 vld;
        int                   theta;
        logic                 exp_dv;
        int                   exp_d;
        longint               exp_unw;
        logic                 exp_avgv;
        int                   exp_avg;
        logic                 exp_rerr;
    } vec_t;

    vec_t tv [23];
    int n_checks;
    int n_fail;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic v, input int th, input logic rdy);
        @(negedge clk);
        clear            = c;
        bus.in_valid     = v;
        bus.theta_in     = th;
        bus.dphase_ready = rdy;
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        rst              = 1'b0;
        clear            = 1'b0;
        bus.in_valid     = 1'b0;
        bus.theta_in     = '0;
        bus.dphase_ready = 1'b1;

        //          clr vld theta    dv  d       unw      avgv avg   rerr
        tv[0]  = '{1'b0, 1'b1, 0,       1'b0, 0,      0,       1'b0, 0,    1'b0};
        tv[1]  = '{1'b0, 1'b1, 1000,    1'b1, 1000,   1000,    1'b0, 0,    1'b0};
        tv[2]  = '{1'b0, 1'b1, 2000,    1'b1, 1000,   2000,    1'b0, 0,    1'b0};
        tv[3]  = '{1'b0, 1'b1, 3000,    1'b1, 1000,   3000,    1'b0, 0,    1'b0};
        tv[4]  = '{1'b0, 1'b1, 4000,    1'b1, 1000,   4000,    1'b1, 1000, 1'b0};
        tv[5]  = '{1'b1, 1'b1, 5000,    1'b0, 0,      0,       1'b0, 0,    1'b0};
        tv[6]  = '{1'b0, 1'b1, 196608,  1'b0, 0,      196608,  1'b0, 0,    1'b0};
        tv[7]  = '{1'b0, 1'b1, -196608, 1'b1, 18558,  215166,  1'b0, 0,    1'b0};
        tv[8]  = '{1'b1, 1'b0, 0,       1'b0, 0,      0,       1'b0, 0,    1'b0};
        tv[9]  = '{1'b0, 1'b1, -196608, 1'b0, 0,      -196608, 1'b0, 0,    1'b0};
        tv[10] = '{1'b0, 1'b1, 196608,  1'b1, -18558, -215166, 1'b0, 0,    1'b0};
        tv[11] = '{1'b1, 1'b0, 0,       1'b0, 0,      0,       1'b0, 0,    1'b0};
        tv[12] = '{1'b0, 1'b1, 0,       1'b0, 0,      0,       1'b0, 0,    1'b0};
        tv[13] = '{1'b0, 1'b1, 205887,  1'b1, 205887, 205887,  1'b0, 0,    1'b0};
        tv[14] = '{1'b0, 1'b1, -205887, 1'b1, 0,      205887,  1'b0, 0,    1'b0};
        tv[15] = '{1'b0, 1'b1, 300000,  1'b1, 94113,  300000,  1'b0, 0,    1'b1};
        tv[16] = '{1'b0, 1'b0, 0,       1'b0, 0,      300000,  1'b0, 0,    1'b1};
        tv[17] = '{1'b1, 1'b1, 300000,  1'b0, 0,      0,       1'b0, 0,    1'b0};
        tv[18] = '{1'b0, 1'b1, 100,     1'b0, 0,      100,     1'b0, 0,    1'b0};
        tv[19] = '{1'b0, 1'b1, 99,      1'b1, -1,     99,      1'b0, 0,    1'b0};
        tv[20] = '{1'b0, 1'b1, 98,      1'b1, -1,     98,      1'b0, 0,    1'b0};
        tv[21] = '{1'b0, 1'b1, 97,      1'b1, -1,     97,      1'b0, 0,    1'b0};
        tv[22] = '{1'b0, 1'b1, 97,      1'b1, 0,      97,      1'b1, -1,   1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset dphase_valid", longint'(bus.dphase_valid), 0);
        chk("reset in_ready", longint'(bus.in_ready), 0);
        chk("reset unwrapped", unwrapped, 0);
        chk("reset avg_out", avg_out, 0);
        chk("reset range_err", longint'(range_err), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("in_ready after release", longint'(bus.in_ready), 1);

        for (int i = 0; i < 23; i++) begin
            drive(tv[i].clr, tv[i].vld, tv[i].theta, 1'b1);
            edge_sample();
            chk($sformatf("v%0d dphase_valid", i), longint'(bus.dphase_valid), longint'(tv[i].exp_dv));
            if (tv[i].exp_dv)
                chk($sformatf("v%0d dphase", i), bus.dphase, tv[i].exp_d);
            chk($sformatf("v%0d unwrapped", i), unwrapped, tv[i].exp_unw);
            chk($sformatf("v%0d avg_valid", i), longint'(avg_valid), longint'(tv[i].exp_avgv));
            chk($sformatf("v%0d avg_out", i), avg_out, tv[i].exp_avg);
            chk($sformatf("v%0d range_err", i), longint'(range_err), longint'(tv[i].exp_rerr));
        end

        // Asynchronous reset in the middle of a stream
        drive(1'b0, 1'b1, 300000, 1'b1);
        edge_sample();
        drive(1'b0, 1'b1, 1000, 1'b1);
        edge_sample();
        chk("pre-reset range_err", longint'(range_err), 1);
        chk("pre-reset dphase_valid", longint'(bus.dphase_valid), 1);
        drive(1'b0, 1'b0, 0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("async rst dphase_valid", longint'(bus.dphase_valid), 0);
        chk("async rst unwrapped", unwrapped, 0);
        chk("async rst avg_out", avg_out, 0);
        chk("async rst range_err", longint'(range_err), 0);
        chk("async rst in_ready", longint'(bus.in_ready), 0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b1, 1000, 1'b1);
        edge_sample();
        chk("post-reset first dphase_valid", longint'(bus.dphase_valid), 0);
        chk("post-reset first unwrapped", unwrapped, 1000);

        // Backpressure: dphase held, in_ready low, then accept and handshake together
        drive(1'b1, 1'b0, 0, 1'b0);
        edge_sample();
        drive(1'b0, 1'b1, 0, 1'b0);
        edge_sample();
        chk("bp first dphase_valid", longint'(bus.dphase_valid), 0);
        drive(1'b0, 1'b1, 500, 1'b0);
        edge_sample();
        chk("bp dphase_valid", longint'(bus.dphase_valid), 1);
        chk("bp dphase 500", bus.dphase, 500);
        drive(1'b0, 1'b1, 900, 1'b0);
        #1;
        chk("bp in_ready low", longint'(bus.in_ready), 0);
        edge_sample();
        chk("bp dphase held", bus.dphase, 500);
        chk("bp unwrapped held", unwrapped, 500);
        drive(1'b0, 1'b1, 900, 1'b1);
        #1;
        chk("bp in_ready high", longint'(bus.in_ready), 1);
        edge_sample();
        chk("bp dphase 400", bus.dphase, 400);
        chk("bp dphase_valid kept", longint'(bus.dphase_valid), 1);
        chk("bp unwrapped 900", unwrapped, 900);
        drive(1'b0, 1'b0, 0, 1'b1);
        edge_sample();
        chk("bp drain dphase_valid", longint'(bus.dphase_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
